// File: rtl/cmplx_amo_engine_pkg.sv
// rtl/cmplx_amo_engine_pkg.sv - shared enums and AMO funct5 encodings for the AMO engine
package cmplx_amo_engine_pkg;

  typedef enum logic [1:0] {
    KIND_AMO  = 2'b00,
    KIND_LR   = 2'b01,
    KIND_SC   = 2'b10,
    KIND_RSVD = 2'b11
  } amo_kind_e;

  localparam logic [4:0] AMO_ADD  = 5'h00;
  localparam logic [4:0] AMO_SWAP = 5'h01;
  localparam logic [4:0] AMO_XOR  = 5'h04;
  localparam logic [4:0] AMO_OR   = 5'h08;
  localparam logic [4:0] AMO_AND  = 5'h0C;
  localparam logic [4:0] AMO_MIN  = 5'h10;
  localparam logic [4:0] AMO_MAX  = 5'h14;
  localparam logic [4:0] AMO_MINU = 5'h18;
  localparam logic [4:0] AMO_MAXU = 5'h1C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DRAIN,
    S_DONE
  } cmplx_amo_fsm_e;

endpackage

// File: rtl/cmplx_amo_engine_if.sv
// rtl/cmplx_amo_engine_if.sv - LSU request/response channel between the AMO engine and the LS pipeline
interface cmplx_amo_engine_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_rdy;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_rdy, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_rdy, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/cmplx_amo_alu.sv
// rtl/cmplx_amo_alu.sv - combinational AMO read-modify-write datapath
module cmplx_amo_alu
  import cmplx_amo_engine_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [4:0]    op_i,
  input  logic [DW-1:0] rdata_i,
  input  logic [DW-1:0] rs2_i,
  output logic [DW-1:0] wdata_o,
  output logic          illegal_o
);

  always_comb begin
    wdata_o   = rdata_i;
    illegal_o = 1'b0;
    case (op_i)
      AMO_ADD:  wdata_o = rdata_i + rs2_i;
      AMO_SWAP: wdata_o = rs2_i;
      AMO_XOR:  wdata_o = rdata_i ^ rs2_i;
      AMO_OR:   wdata_o = rdata_i | rs2_i;
      AMO_AND:  wdata_o = rdata_i & rs2_i;
      AMO_MIN:  wdata_o = ($signed(rdata_i) < $signed(rs2_i)) ? rdata_i : rs2_i;
      AMO_MAX:  wdata_o = ($signed(rdata_i) > $signed(rs2_i)) ? rdata_i : rs2_i;
      AMO_MINU: wdata_o = (rdata_i < rs2_i) ? rdata_i : rs2_i;
      AMO_MAXU: wdata_o = (rdata_i > rs2_i) ? rdata_i : rs2_i;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cmplx_amo_engine.sv
// rtl/cmplx_amo_engine.sv - AMO/LR/SC sequencer driving the LS pipeline; LR/SC built only with KUDU_AMO_LRSC_EN
module cmplx_amo_engine
  import cmplx_amo_engine_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int RESV_GRAN_LOG2 = 3,
  parameter int RESV_TIMEOUT   = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               start_i,
  input  logic [1:0]         kind_i,
  input  logic [4:0]         op_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [DW-1:0]      rs2_i,
  input  logic [4:0]         rd_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               rd_wr_o,
  output logic [4:0]         rd_o,
  output logic [DW-1:0]      rd_wdata_o,
  cmplx_amo_engine_if.master lsu,
  input  logic               snoop_wr_valid_i,
  input  logic [AW-1:0]      snoop_wr_addr_i
);

  cmplx_amo_fsm_e state_q, state_d;
  amo_kind_e      kind_q, kind_d;
  logic [4:0]     op_q, op_d, rd_q, rd_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  rs2_q, rs2_d, rdata_q, rdata_d, result_q, result_d;
  logic           err_q, err_d, rdwr_q, rdwr_d;
  logic           req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic           resv_set, resv_clr, amo_wr_done;
  logic           req_hs, alu_illegal;
  logic [4:0]     alu_op;
  logic [DW-1:0]  alu_wdata;

  assign req_hs = lsu.req_valid && lsu.req_rdy;
  // While idle the ALU decodes the incoming funct5 so an illegal op is rejected at start.
  assign alu_op = (state_q == S_IDLE) ? op_i : op_q;

  cmplx_amo_alu #(.DW(DW)) u_alu (
    .op_i      (alu_op),
    .rdata_i   (rdata_q),
    .rs2_i     (rs2_q),
    .wdata_o   (alu_wdata),
    .illegal_o (alu_illegal)
  );

`ifdef KUDU_AMO_LRSC_EN
  localparam int GW = AW - RESV_GRAN_LOG2;
  localparam int CW = $clog2(RESV_TIMEOUT + 1);

  logic          resv_valid_q, resv_valid_d;
  logic [GW-1:0] resv_gran_q, resv_gran_d;
  logic [CW-1:0] resv_cnt_q, resv_cnt_d;
  logic          snoop_hit, sc_ok, amo_hit;

  assign snoop_hit = resv_valid_q && snoop_wr_valid_i &&
                     (snoop_wr_addr_i[AW-1:RESV_GRAN_LOG2] == resv_gran_q);
  assign sc_ok     = resv_valid_q && !snoop_hit &&
                     (addr_i[AW-1:RESV_GRAN_LOG2] == resv_gran_q);
  assign amo_hit   = amo_wr_done && (addr_q[AW-1:RESV_GRAN_LOG2] == resv_gran_q);

  // A completing LR outranks every clear source raised in the same cycle.
  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_gran_d  = resv_gran_q;
    resv_cnt_d   = resv_cnt_q;
    if (resv_set) begin
      resv_valid_d = 1'b1;
      resv_gran_d  = addr_q[AW-1:RESV_GRAN_LOG2];
      resv_cnt_d   = CW'(RESV_TIMEOUT);
    end else if (resv_clr || snoop_hit || amo_hit || (resv_valid_q && resv_cnt_q == CW'(1))) begin
      resv_valid_d = 1'b0;
      resv_cnt_d   = '0;
    end else if (resv_valid_q) begin
      resv_cnt_d   = resv_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resv_valid_q <= 1'b0;
      resv_gran_q  <= '0;
      resv_cnt_q   <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_gran_q  <= resv_gran_d;
      resv_cnt_q   <= resv_cnt_d;
    end
  end
`else
  localparam int unused_resv_params = RESV_GRAN_LOG2 + RESV_TIMEOUT;
  logic unused_resv;
  assign unused_resv = ^{resv_set, resv_clr, amo_wr_done, snoop_wr_valid_i, snoop_wr_addr_i};
`endif

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    result_d    = result_q;
    err_d       = err_q;
    rdwr_d      = rdwr_q;
    resv_set    = 1'b0;
    resv_clr    = 1'b0;
    amo_wr_done = 1'b0;
    if (flush_i) begin
      resv_clr = 1'b1;
      // An accepted request still owes one response, which DRAIN absorbs.
      case (state_q)
        S_RD_REQ, S_WR_REQ:   state_d = req_hs ? S_DRAIN : S_IDLE;
        S_RD_WAIT, S_WR_WAIT: state_d = lsu.rsp_valid ? S_IDLE : S_DRAIN;
        S_DRAIN:              state_d = lsu.rsp_valid ? S_IDLE : S_DRAIN;
        default:              state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          kind_d   = amo_kind_e'(kind_i);
          op_d     = op_i;
          addr_d   = addr_i;
          rs2_d    = rs2_i;
          rd_d     = rd_i;
          err_d    = 1'b0;
          rdwr_d   = 1'b0;
          result_d = '0;
          case (amo_kind_e'(kind_i))
            KIND_AMO: begin
              state_d = alu_illegal ? S_DONE : S_RD_REQ;
              err_d   = alu_illegal;
            end
`ifdef KUDU_AMO_LRSC_EN
            KIND_LR: state_d = S_RD_REQ;
            KIND_SC: begin
              resv_clr = 1'b1;
              if (sc_ok) begin
                state_d = S_WR_REQ;
              end else begin
                state_d  = S_DONE;
                rdwr_d   = 1'b1;
                result_d = DW'(1);
              end
            end
`endif
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
        S_RD_REQ: if (req_hs) state_d = S_RD_WAIT;
        S_RD_WAIT: if (lsu.rsp_valid) begin
          if (lsu.rsp_err) begin
            state_d  = S_DONE;
            err_d    = 1'b1;
            resv_clr = 1'b1;
          end else begin
            rdata_d  = lsu.rsp_rdata;
            result_d = lsu.rsp_rdata;
            rdwr_d   = 1'b1;
            if (kind_q == KIND_LR) begin
              state_d  = S_DONE;
              resv_set = 1'b1;
            end else begin
              state_d = S_WR_REQ;
            end
          end
        end
        S_WR_REQ: if (req_hs) state_d = S_WR_WAIT;
        S_WR_WAIT: if (lsu.rsp_valid) begin
          state_d = S_DONE;
          if (lsu.rsp_err) begin
            err_d    = 1'b1;
            rdwr_d   = 1'b0;
            resv_clr = 1'b1;
          end else if (kind_q == KIND_AMO) begin
            amo_wr_done = 1'b1;
          end else begin
            rdwr_d = 1'b1;
          end
        end
        S_DRAIN: if (lsu.rsp_valid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    req_valid_d = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
    req_we_d    = (state_d == S_WR_REQ);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      kind_q      <= KIND_AMO;
      op_q        <= '0;
      addr_q      <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rdata_q     <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      rdwr_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      result_q    <= result_d;
      err_q       <= err_d;
      rdwr_q      <= rdwr_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE) && !flush_i;
  assign err_o         = done_o && err_q;
  assign rd_wr_o       = done_o && rdwr_q;
  assign rd_o          = rd_q;
  assign rd_wdata_o    = result_q;
  assign lsu.req_valid = req_valid_q;
  assign lsu.req_we    = req_we_q;
  assign lsu.req_addr  = addr_q;
  assign lsu.req_wdata = (kind_q == KIND_AMO) ? alu_wdata : rs2_q;

endmodule

// File: tb/tb_cmplx_amo_engine.sv
// tb/tb_cmplx_amo_engine.sv - directed self-checking bench for cmplx_amo_engine (64-bit and 32-bit instances)
module tb_cmplx_amo_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic        start32 = 1'b0;
  logic [1:0]  kind = 2'b00;
  logic [4:0]  op = 5'h00;
  logic [31:0] addr = 32'h0;
  logic [63:0] rs2 = 64'h0;
  logic [4:0]  rd = 5'd0;
  logic        snoop_v = 1'b0;
  logic [31:0] snoop_a = 32'h0;

  logic        busy_o, done_o, err_o, rd_wr_o;
  logic [4:0]  rd_o;
  logic [63:0] rd_wdata_o;
  logic        busy32, done32, err32, rdwr32;
  logic [4:0]  rd32;
  logic [31:0] rdwd32;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cmplx_amo_engine_if #(.DW(64), .AW(32)) lsu64 ();
  cmplx_amo_engine_if #(.DW(32), .AW(32)) lsu32 ();

  cmplx_amo_engine #(.DW(64), .AW(32), .RESV_GRAN_LOG2(3), .RESV_TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start), .kind_i(kind), .op_i(op),
    .addr_i(addr), .rs2_i(rs2), .rd_i(rd), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_wr_o(rd_wr_o), .rd_o(rd_o), .rd_wdata_o(rd_wdata_o), .lsu(lsu64),
    .snoop_wr_valid_i(snoop_v), .snoop_wr_addr_i(snoop_a)
  );

  cmplx_amo_engine #(.DW(32), .AW(32), .RESV_GRAN_LOG2(3), .RESV_TIMEOUT(64)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .start_i(start32), .kind_i(kind), .op_i(op),
    .addr_i(addr), .rs2_i(rs2[31:0]), .rd_i(rd), .busy_o(busy32), .done_o(done32), .err_o(err32),
    .rd_wr_o(rdwr32), .rd_o(rd32), .rd_wdata_o(rdwd32), .lsu(lsu32),
    .snoop_wr_valid_i(snoop_v), .snoop_wr_addr_i(snoop_a)
  );

  // 64-bit LSU model: configurable latency, single outstanding request.
  logic [63:0] mem_val = 64'h0;
  logic [63:0] last_wdata = 64'h0;
  logic [31:0] last_addr = 32'h0;
  logic        err_inj = 1'b0;
  int          lat = 1;
  int          dly = 0;
  int          req_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;

  assign lsu64.req_rdy   = 1'b1;
  assign lsu64.rsp_valid = (dly == 1);

  always @(posedge clk) begin
    if (lsu64.req_valid && lsu64.req_rdy) begin
      dly             <= lat;
      lsu64.rsp_rdata <= mem_val;
      lsu64.rsp_err   <= err_inj;
      req_cnt         <= req_cnt + 1;
      last_addr       <= lsu64.req_addr;
      if (lsu64.req_we) begin
        wr_cnt     <= wr_cnt + 1;
        last_wdata <= lsu64.req_wdata;
      end
    end else if (dly > 0) begin
      dly <= dly - 1;
    end
    if (done_o) done_cnt <= done_cnt + 1;
  end

  // 32-bit LSU model: zero-wait, memory word fixed at 0x7FFFFFFF.
  int          dly32 = 0;
  int          wr_cnt32 = 0;
  logic [31:0] last_wdata32 = 32'h0;

  assign lsu32.req_rdy   = 1'b1;
  assign lsu32.rsp_valid = (dly32 == 1);

  always @(posedge clk) begin
    if (lsu32.req_valid && lsu32.req_rdy) begin
      dly32           <= 1;
      lsu32.rsp_rdata <= 32'h7FFF_FFFF;
      lsu32.rsp_err   <= 1'b0;
      if (lsu32.req_we) begin
        wr_cnt32     <= wr_cnt32 + 1;
        last_wdata32 <= lsu32.req_wdata;
      end
    end else if (dly32 > 0) begin
      dly32 <= dly32 - 1;
    end
  end

  // Starts one operation on the 64-bit engine; cyc is the cycle index (c0 = start edge) of done_o, 0 if none.
  task automatic run64(input logic [1:0] k, input logic [4:0] o, input logic [31:0] a,
                       input logic [63:0] r, input logic snp, output int cyc,
                       output logic e, output logic w, output logic [63:0] d);
    kind = k; op = o; addr = a; rs2 = r; rd = 5'd7; start = 1'b1;
    snoop_v = snp; snoop_a = a;
    @(negedge clk);
    start = 1'b0; snoop_v = 1'b0; kind = 2'b11; op = 5'h1F; addr = 32'hFFFF_FFFF;
    cyc = 0; e = 1'b0; w = 1'b0; d = 64'h0;
    for (int i = 1; i <= 40; i++) begin
      if (done_o) begin
        cyc = i; e = err_o; w = rd_wr_o; d = rd_wdata_o;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy_o !== 1'b0 || busy32 !== 1'b0) $display("FAIL reset_busy got %b/%b exp 0/0", busy_o, busy32);
    else pass_cnt++;
    total_cnt++;
    if (done_o !== 1'b0 || err_o !== 1'b0 || rd_wr_o !== 1'b0) $display("FAIL reset_done got %b%b%b exp 000", done_o, err_o, rd_wr_o);
    else pass_cnt++;
    total_cnt++;
    if (lsu64.req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", lsu64.req_valid);
    else pass_cnt++;
    total_cnt++;
    if (rd_wdata_o !== 64'h0 || rd_o !== 5'd0) $display("FAIL reset_rd got %h/%0d exp 0/0", rd_wdata_o, rd_o);
    else pass_cnt++;
  endtask

  task automatic test_amo32_add;
    int cyc;
    kind = 2'b00; op = 5'h00; addr = 32'h40; rs2 = 64'h1; rd = 5'd9; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; op = 5'h1F;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done32) begin cyc = i; break; end
      @(negedge clk);
    end
    total_cnt++;
    if (cyc !== 5) $display("FAIL amo32_latency got %0d exp 5", cyc);
    else pass_cnt++;
    total_cnt++;
    if (rdwd32 !== 32'h7FFF_FFFF || rdwr32 !== 1'b1 || err32 !== 1'b0 || rd32 !== 5'd9)
      $display("FAIL amo32_rd got %h wr=%b err=%b rd=%0d exp 7fffffff wr=1 err=0 rd=9", rdwd32, rdwr32, err32, rd32);
    else pass_cnt++;
    total_cnt++;
    if (last_wdata32 !== 32'h8000_0000 || wr_cnt32 !== 1) $display("FAIL amo32_wdata got %h n=%0d exp 80000000 n=1", last_wdata32, wr_cnt32);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_amo64_ops;
    int cyc, w0;
    logic e, w;
    logic [63:0] d;
    logic [4:0]  ops [4] = '{5'h10, 5'h1C, 5'h14, 5'h0C};
    logic [63:0] mems[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'hF0F0};
    logic [63:0] srcs[4] = '{64'h5, 64'h5, 64'h5, 64'hFF00};
    logic [63:0] exps[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 64'h5, 64'hF000};
    for (int t = 0; t < 4; t++) begin
      mem_val = mems[t]; w0 = wr_cnt;
      run64(2'b00, ops[t], 32'h800 + 32'(t * 8), srcs[t], 1'b0, cyc, e, w, d);
      total_cnt++;
      if (cyc !== 5 || e !== 1'b0 || w !== 1'b1) $display("FAIL amo64_done[%0d] got cyc=%0d err=%b wr=%b exp 5/0/1", t, cyc, e, w);
      else pass_cnt++;
      total_cnt++;
      if (d !== mems[t] || rd_o !== 5'd7) $display("FAIL amo64_rd[%0d] got %h rd=%0d exp %h rd=7", t, d, rd_o, mems[t]);
      else pass_cnt++;
      total_cnt++;
      if (last_wdata !== exps[t] || wr_cnt !== w0 + 1 || last_addr !== 32'h800 + 32'(t * 8))
        $display("FAIL amo64_wdata[%0d] got %h @%h exp %h @%h", t, last_wdata, last_addr, exps[t], 32'h800 + 32'(t * 8));
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal;
    int cyc, r0;
    logic e, w;
    logic [63:0] d;
    logic [1:0] kinds[2] = '{2'b00, 2'b11};
    logic [4:0] opsx[2]  = '{5'h02, 5'h00};
    for (int t = 0; t < 2; t++) begin
      r0 = req_cnt;
      run64(kinds[t], opsx[t], 32'h900, 64'h1, 1'b0, cyc, e, w, d);
      total_cnt++;
      if (cyc !== 1 || e !== 1'b1 || w !== 1'b0 || req_cnt !== r0)
        $display("FAIL illegal[%0d] got cyc=%0d err=%b wr=%b reqs=%0d exp 1/1/0/0", t, cyc, e, w, req_cnt - r0);
      else pass_cnt++;
    end
  endtask

  task automatic test_rd_err;
    int cyc, r0;
    logic e, w;
    logic [63:0] d;
    err_inj = 1'b1; r0 = req_cnt;
    run64(2'b00, 5'h00, 32'hA00, 64'h1, 1'b0, cyc, e, w, d);
    err_inj = 1'b0;
    total_cnt++;
    if (cyc !== 3 || e !== 1'b1 || w !== 1'b0 || req_cnt !== r0 + 1)
      $display("FAIL rd_err got cyc=%0d err=%b wr=%b reqs=%0d exp 3/1/0/1", cyc, e, w, req_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_flush_drain;
    int n, d0, w0, r0;
    lat = 5; d0 = done_cnt; w0 = wr_cnt; r0 = req_cnt; mem_val = 64'h11;
    kind = 2'b00; op = 5'h00; addr = 32'hB00; rs2 = 64'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    lat = 1;
    total_cnt++;
    if (n !== 4) $display("FAIL flush_drain_cycles got %0d exp 4", n);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== d0 || wr_cnt !== w0 || req_cnt !== r0 + 1)
      $display("FAIL flush_no_done got done=%0d wr=%0d req=%0d exp 0/0/1", done_cnt - d0, wr_cnt - w0, req_cnt - r0);
    else pass_cnt++;
  endtask

`ifdef KUDU_AMO_LRSC_EN
  task automatic test_lrsc;
    int cyc, w0, r0;
    logic e, w;
    logic [63:0] d;
    mem_val = 64'h1234;
    run64(2'b01, 5'h00, 32'h1000, 64'h0, 1'b0, cyc, e, w, d);
    total_cnt++;
    if (cyc !== 3 || e !== 1'b0 || w !== 1'b1 || d !== 64'h1234) $display("FAIL lr got cyc=%0d err=%b wr=%b d=%h exp 3/0/1/1234", cyc, e, w, d);
    else pass_cnt++;
    w0 = wr_cnt;
    run64(2'b10, 5'h00, 32'h1004, 64'hABCD, 1'b0, cyc, e, w, d);
    total_cnt++;
    if (cyc !== 3 || w !== 1'b1 || d !== 64'h0 || wr_cnt !== w0 + 1 || last_wdata !== 64'hABCD || last_addr !== 32'h1004)
      $display("FAIL sc_ok got cyc=%0d d=%h wrs=%0d wd=%h @%h exp 3/0/1/abcd@1004", cyc, d, wr_cnt - w0, last_wdata, last_addr);
    else pass_cnt++;
    r0 = req_cnt;
    run64(2'b10, 5'h00, 32'h1004, 64'hABCD, 1'b0, cyc, e, w, d);
    total_cnt++;
    if (cyc !== 1 || w !== 1'b1 || e !== 1'b0 || d !== 64'h1 || req_cnt !== r0)
      $display("FAIL sc_again got cyc=%0d wr=%b d=%h reqs=%0d exp 1/1/1/0", cyc, w, d, req_cnt - r0);
    else pass_cnt++;
  endtask

  // Each case is LR then SC to the same granule after a disturbance; exp_rd is the SC result.
  task automatic test_resv_kill;
    int cyc, w0;
    logic e, w;
    logic [63:0] d;
    logic [31:0] a;
    logic [63:0] exp_rd;
    for (int t = 0; t < 5; t++) begin
      a = 32'h2000 + 32'(t * 32'h100);
      run64(2'b01, 5'h00, a, 64'h0, 1'b0, cyc, e, w, d);
      exp_rd = 64'h1;
      case (t)
        0: begin snoop_v = 1'b1; snoop_a = a + 32'h6; @(negedge clk); snoop_v = 1'b0; end
        1: repeat (70) @(negedge clk);
        2: begin repeat (40) @(negedge clk); exp_rd = 64'h0; end
        3: run64(2'b00, 5'h01, a + 32'h4, 64'h9, 1'b0, cyc, e, w, d);
        default: ;
      endcase
      w0 = wr_cnt;
      run64(2'b10, 5'h00, a, 64'h77, (t == 4), cyc, e, w, d);
      total_cnt++;
      if (d !== exp_rd || w !== 1'b1 || wr_cnt !== w0 + ((exp_rd == 64'h0) ? 1 : 0))
        $display("FAIL resv_kill[%0d] got rd=%h wr=%b stores=%0d exp rd=%h", t, d, w, wr_cnt - w0, exp_rd);
      else pass_cnt++;
    end
  endtask
`else
  task automatic test_lrsc_disabled;
    int cyc, r0;
    logic e, w;
    logic [63:0] d;
    for (int t = 0; t < 2; t++) begin
      r0 = req_cnt;
      run64((t == 0) ? 2'b01 : 2'b10, 5'h00, 32'h1000, 64'h0, 1'b0, cyc, e, w, d);
      total_cnt++;
      if (cyc !== 1 || e !== 1'b1 || w !== 1'b0 || req_cnt !== r0)
        $display("FAIL lrsc_disabled[%0d] got cyc=%0d err=%b wr=%b reqs=%0d exp 1/1/0/0", t, cyc, e, w, req_cnt - r0);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_amo32_add();
    test_amo64_ops();
    test_illegal();
    test_rd_err();
    test_flush_drain();
`ifdef KUDU_AMO_LRSC_EN
    test_lrsc();
    test_resv_kill();
`else
    test_lrsc_disabled();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cmplx_amo_engine.md
# cmplx_amo_engine

Parametrised successor to the single-width complex-instruction AMO sequencer. It accepts one atomic instruction at a time from the issuer (AMO read-modify-write, LR, SC) and sequences read/write requests to the LS pipeline. It computes the AMO result and returns the rd value to the register-file writeback path. Compared with the previous generation, it adds a data-width parameter, an LR/SC reservation with snoop kill and timeout, flush draining of in-flight LSU responses, and a full valid/ready LSU handshake.

## Interface
- DW, 32: data width of rs2, LSU data and the rd result (32 or 64).
- AW, 32: address width.
- RESV_GRAN_LOG2, 3: log2 of the reservation granule in bytes.
- RESV_TIMEOUT, 64: cycles after LR completion before the reservation self-clears (≥1).
- clk_i  in  1  clock; sole clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush; aborts the current operation.
- start_i  in  1  start request; accepted only when busy_o=0.
- kind_i  in  2  operation kind: 00 AMO, 01 LR, 10 SC, 11 reserved.
- op_i  in  5  AMO funct5 (insn[31:27]).
- addr_i  in  AW  rs1 address.
- rs2_i  in  DW  rs2 value.
- rd_i  in  5  destination register.
- busy_o  out  1  engine not IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies done_o: access fault or illegal kind.
- rd_wr_o  out  1  qualifies done_o: write rd_wdata_o to rd_o.
- rd_o  out  5  captured rd.
- rd_wdata_o  out  DW  rd result.
- lsu_req_valid_o  out  1  LSU request valid.
- lsu_req_rdy_i  in  1  LSU request ready.
- lsu_req_we_o  out  1  1 = store, 0 = load.
- lsu_req_addr_o  out  AW  request address.
- lsu_req_wdata_o  out  DW  store data.
- lsu_rsp_valid_i  in  1  LSU response valid; one per accepted request, in order.
- lsu_rsp_err_i  in  1  response fault.
- lsu_rsp_rdata_i  in  DW  load data.
- snoop_wr_valid_i  in  1  another agent stored to memory.
- snoop_wr_addr_i  in  AW  address of that store.

## Operation
- On start_i with busy_o=0, capture kind, op, addr, rs2 and rd. Later changes to these inputs are ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DRAIN, DONE.
- AMO: IDLE→RD_REQ→RD_WAIT. On an OK response, capture rdata and go to WR_REQ (wdata = ALU(op, rdata, rs2)), then WR_WAIT, then DONE. rd_wdata_o = old memory value.
- LR: IDLE→RD_REQ→RD_WAIT→DONE. rd_wdata_o = rdata. On success, set the reservation (addr >> RESV_GRAN_LOG2) and load the timeout counter.
- SC: if the reservation is valid and the granule matches, go IDLE→WR_REQ→WR_WAIT→DONE with rd_wdata_o=0. Otherwise go IDLE→DONE with rd_wdata_o=1 and no LSU access. Every SC clears the reservation.
- ALU ops (funct5): 00 ADD (mod 2^DW), 01 SWAP, 04 XOR, 08 OR, 0C AND, 10 MIN, 14 MAX (signed DW compare), 18 MINU, 1C MAXU. Any other funct5 is treated as illegal: DONE with err_o=1 and no LSU access.
- kind 11 is illegal: DONE with err_o=1.
- Response error in RD_WAIT or WR_WAIT: go to DONE with err_o=1, rd_wr_o=0, no write phase, and clear the reservation.
- The reservation is cleared by any of:
  - a snoop whose granule matches;
  - completion of an AMO write to the reserved granule;
  - the timeout counter reaching 0 (decremented every cycle while valid);
  - flush_i.
- Flush:
  - In RD_REQ or WR_REQ without a handshake that cycle: go to IDLE. Dropping an unaccepted request is legal.
  - In RD_WAIT or WR_WAIT, or in a REQ state with a handshake that same cycle: go to DRAIN and stay busy until lsu_rsp_valid_i, then IDLE. There is no done_o.
  - In DONE: done_o is suppressed and the state goes to IDLE.
- start_i is ignored while busy_o=1.

## Timing
- Reset: state IDLE; all outputs 0; reservation invalid; counter 0.
- lsu_req_valid_o is registered and asserted only in RD_REQ and WR_REQ. It is held until lsu_req_rdy_i. Address and data stay stable while valid.
- done_o is a 1-cycle pulse in DONE. rd_wr_o, err_o and rd_wdata_o are valid only with done_o; busy_o=1 in DONE.
- With a zero-wait LSU (ready and response in the next cycle):
  - AMO: start at c0, done at c5.
  - LR: start at c0, done at c3.
  - Successful SC: done at c3.
  - Failed SC: done at c1.
- A snoop match in the same cycle as an SC start wins: the SC fails.
- An LR completing in the same cycle as a snoop match sets the reservation (the LR is later).

## Configuration
- KUDU_AMO_LRSC_EN defined: LR/SC and the reservation logic (register, counter, snoop compare) are built in.
- Not defined: LR and SC kinds are illegal (done_o with err_o=1, no LSU access); the reservation logic is absent; the snoop ports are unused; the AMO path is unchanged.

## Structure
- super_pkg gains: the amo_kind_e enum (AMO/LR/SC/RSVD), the AMO funct5 localparams, and the cmplx_amo_fsm_e enum.
- Sub-module cmplx_amo_alu: combinational, parameter DW, inputs op/rdata/rs2, outputs wdata and an illegal flag.

## Test plan
- DW=32, AMOADD with mem=0x7FFFFFFF and rs2=1 → write 0x80000000; rd_wdata_o=0x7FFFFFFF; done_o at c5 with a zero-wait LSU.
- DW=64, AMOMIN with mem=-2 and rs2=5 → write -2; AMOMAXU with mem=0xFFFF_FFFF_FFFF_FFFE and rs2=5 → write mem unchanged.
- LR 0x1000, then SC 0x1004 (same 8-byte granule) → store issued, rd=0. A second SC → no LSU request, rd=1, done at c1.
- LR 0x2000, then a snoop to 0x2006 (or 64 idle cycles), then SC 0x2000 → rd=1 and no store issued.
- AMO with flush_i in RD_WAIT → DRAIN; busy_o stays high until the response; no done_o; no write request issued.
- AMO read response with err → done_o with err_o=1, rd_wr_o=0, no write phase.
- Without KUDU_AMO_LRSC_EN: LR start → done_o with err_o=1 at c1, no LSU access.
